// File: rtl/sr_regfile_sb.sv
// sr_regfile_sb: register file with NUM_RD combinational read ports, prioritised
// bypass, same-cycle write bypass, and a per-register pending-write scoreboard
// that stalls reads of operands whose multi-cycle producer has not written back.
module sr_regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         dbgAddr,
    output logic [DATA_W-1:0]         dbgData,
    input  logic [NUM_RD*ADDR_W-1:0]  rdAddr,
    input  logic [NUM_RD-1:0]         rdUse,
    output logic [NUM_RD*DATA_W-1:0]  rdData,
    output logic [NUM_RD-1:0]         rdStall,
    input  logic [NUM_FWD*ADDR_W-1:0] fwdAddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwdData,
    input  logic [NUM_FWD-1:0]        fwdVld,
    input  logic                      wrEn,
    input  logic [ADDR_W-1:0]         wrAddr,
    input  logic [DATA_W-1:0]         wrData,
    input  logic                      issueEn,
    input  logic [ADDR_W-1:0]         issueAddr,
    input  logic                      killEn,
    input  logic [ADDR_W-1:0]         killAddr,
    output logic                      sbErr
);
    localparam int REGS = 2**ADDR_W;
    localparam int SW   = CNT_W + 2;   // signed headroom for +1 and -2

    logic [REGS-1:0][DATA_W-1:0] r_mem;
    logic [REGS-1:0][CNT_W-1:0]  r_pc;
    logic                        r_sbErr;

    logic [REGS-1:0][CNT_W-1:0]  w_pcNxt;
    logic [REGS-1:0]             w_err;

    // Register array: writeback commits on posedge, x0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (wrEn && wrAddr != '0) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    // Next pending count per register: net the issue/write/kill events, clamp
    // to [0, max]. A write with nothing pending is an ordinary writeback, so
    // only a kill driving the count negative is flagged as underflow.
    always_comb begin
        w_pcNxt = '0;
        w_err   = '0;
        for (int r = 1; r < REGS; r++) begin
            logic          inc, wdec, kdec;
            logic [SW-1:0] sum;
            inc  = issueEn && (issueAddr == ADDR_W'(r));
            wdec = wrEn    && (wrAddr    == ADDR_W'(r));
            kdec = killEn  && (killAddr  == ADDR_W'(r));
            sum  = {2'b00, r_pc[r]} + SW'(inc) - SW'(wdec) - SW'(kdec);
            if (sum[SW-1]) begin
                w_pcNxt[r] = '0;
                w_err[r]   = kdec;
            end else if (sum[SW-2]) begin
                w_pcNxt[r] = '1;
                w_err[r]   = 1'b1;
            end else begin
                w_pcNxt[r] = sum[CNT_W-1:0];
            end
        end
    end

    // Scoreboard state and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_sbErr <= 1'b0;
        end else begin
            r_pc    <= w_pcNxt;
            r_sbErr <= r_sbErr | (|w_err);
        end
    end

    assign sbErr   = r_sbErr;
    assign dbgData = (dbgAddr == '0) ? '0 : r_mem[dbgAddr];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic [CNT_W-1:0]  w_pc;
        logic              w_wrHit;
        logic              w_pend;

        assign w_addr  = rdAddr[i*ADDR_W +: ADDR_W];
        assign w_wrHit = wrEn && (wrAddr == w_addr);
        assign w_pc    = r_pc[w_addr];

        // Operand select: youngest valid bypass, then writeback, then array
        always_comb begin
            w_data = r_mem[w_addr];
            if (w_wrHit) w_data = wrData;
            for (int j = NUM_FWD-1; j >= 0; j--) begin
                if (fwdVld[j] && fwdAddr[j*ADDR_W +: ADDR_W] == w_addr)
                    w_data = fwdData[j*DATA_W +: DATA_W];
            end
            if (w_addr == '0) w_data = '0;
        end

        // Still pending after crediting a same-cycle writeback; bypass hits
        // never clear this since the in-flight producer is younger
        always_comb begin
            if (w_wrHit) w_pend = (w_pc > CNT_W'(1));
            else         w_pend = (w_pc != '0);
        end

        assign rdData[i*DATA_W +: DATA_W] = w_data;
        assign rdStall[i] = rdUse[i] && (w_addr != '0) && w_pend;
    end

endmodule

// File: tb/tb_sr_regfile_sb.sv
// Directed bench for sr_regfile_sb with hand-computed expectations.
module tb_sr_regfile_sb;
    localparam int DATA_W = 32, ADDR_W = 5, NUM_RD = 2, NUM_FWD = 2, CNT_W = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [ADDR_W-1:0]         dbgAddr;
    logic [DATA_W-1:0]         dbgData;
    logic [NUM_RD*ADDR_W-1:0]  rdAddr;
    logic [NUM_RD-1:0]         rdUse;
    logic [NUM_RD*DATA_W-1:0]  rdData;
    logic [NUM_RD-1:0]         rdStall;
    logic [NUM_FWD*ADDR_W-1:0] fwdAddr;
    logic [NUM_FWD*DATA_W-1:0] fwdData;
    logic [NUM_FWD-1:0]        fwdVld;
    logic                      wrEn;
    logic [ADDR_W-1:0]         wrAddr;
    logic [DATA_W-1:0]         wrData;
    logic                      issueEn;
    logic [ADDR_W-1:0]         issueAddr;
    logic                      killEn;
    logic [ADDR_W-1:0]         killAddr;
    logic                      sbErr;

    int n_chk = 0;
    int n_err = 0;

    sr_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                    .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .dbgAddr(dbgAddr), .dbgData(dbgData),
        .rdAddr(rdAddr), .rdUse(rdUse), .rdData(rdData), .rdStall(rdStall),
        .fwdAddr(fwdAddr), .fwdData(fwdData), .fwdVld(fwdVld),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .issueEn(issueEn), .issueAddr(issueAddr),
        .killEn(killEn), .killAddr(killAddr), .sbErr(sbErr));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge, then let combinational reads settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input logic [ADDR_W-1:0] a, input logic use_);
        rdAddr[0*ADDR_W +: ADDR_W] = a;
        rdUse[0] = use_;
    endtask

    task automatic idle();
        wrEn = 0; issueEn = 0; killEn = 0; fwdVld = '0;
    endtask

    initial begin
        rst_n = 0; dbgAddr = 0; rdAddr = '0; rdUse = '0;
        fwdAddr = '0; fwdData = '0; fwdVld = '0;
        wrEn = 0; wrAddr = 0; wrData = 0;
        issueEn = 0; issueAddr = 0; killEn = 0; killAddr = 0;

        // ---- reset state
        rd0(5'd5, 1'b1); dbgAddr = 5'd5;
        #2;
        chk("rst_rdData", rdData[31:0], 32'h0);
        chk("rst_rdStall", {30'd0, rdStall}, 32'h0);
        chk("rst_sbErr", {31'd0, sbErr}, 32'h0);
        chk("rst_dbg", dbgData, 32'h0);
        tick(); rst_n = 1;

        // ---- write x5 then async reset mid-cycle
        wrEn = 1; wrAddr = 5'd5; wrData = 32'hDEAD;
        tick(); idle(); #1;
        chk("x5_written", rdData[31:0], 32'hDEAD);
        chk("x5_dbg", dbgData, 32'hDEAD);
        #2 rst_n = 0; #1;
        chk("async_rst_rd", rdData[31:0], 32'h0);
        chk("async_rst_dbg", dbgData, 32'h0);
        chk("async_rst_err", {31'd0, sbErr}, 32'h0);
        tick(); rst_n = 1;

        // ---- bypass priority on read port 1
        wrEn = 1; wrAddr = 5'd3; wrData = 32'd1;
        tick();
        wrData = 32'd2;
        fwdAddr = {5'd3, 5'd3}; fwdData = {32'd3, 32'd4}; fwdVld = 2'b11;
        rdAddr[1*ADDR_W +: ADDR_W] = 5'd3; rdUse[1] = 1;
        #1 chk("prio_fwd0", rdData[63:32], 32'd4);
        fwdVld = 2'b10;
        #1 chk("prio_fwd1", rdData[63:32], 32'd3);
        fwdVld = 2'b00;
        #1 chk("prio_wr", rdData[63:32], 32'd2);
        wrEn = 0;
        #1 chk("prio_arr", rdData[63:32], 32'd1);
        dbgAddr = 5'd3;
        #1 chk("prio_dbg", dbgData, 32'd1);
        rdUse[1] = 0;

        // ---- load-use on x7
        issueEn = 1; issueAddr = 5'd7; rd0(5'd7, 1'b1);
        #1 chk("lu_same_cyc", {31'd0, rdStall[0]}, 32'd0);
        tick(); idle();
        #1 chk("lu_stall", {31'd0, rdStall[0]}, 32'd1);
        rd0(5'd7, 1'b0);
        #1 chk("lu_nouse", {31'd0, rdStall[0]}, 32'd0);
        rd0(5'd7, 1'b1);
        wrEn = 1; wrAddr = 5'd7; wrData = 32'h55;
        #1 chk("lu_wb_stall", {31'd0, rdStall[0]}, 32'd0);
        chk("lu_wb_data", rdData[31:0], 32'h55);
        tick(); idle();
        #1 chk("lu_after", {31'd0, rdStall[0]}, 32'd0);
        chk("lu_after_data", rdData[31:0], 32'h55);
        chk("lu_sbErr", {31'd0, sbErr}, 32'd0);

        // ---- double issue on x9
        issueEn = 1; issueAddr = 5'd9; rd0(5'd9, 1'b1);
        tick(); tick(); idle();
        wrEn = 1; wrAddr = 5'd9; wrData = 32'h99;
        #1 chk("dbl_wb1_stall", {31'd0, rdStall[0]}, 32'd1);
        tick(); idle();
        #1 chk("dbl_mid_stall", {31'd0, rdStall[0]}, 32'd1);
        wrEn = 1; wrAddr = 5'd9; wrData = 32'h9A;
        #1 chk("dbl_wb2_stall", {31'd0, rdStall[0]}, 32'd0);
        tick(); idle();
        #1 chk("dbl_done", {31'd0, rdStall[0]}, 32'd0);
        chk("dbl_data", rdData[31:0], 32'h9A);

        // ---- x0 is inert
        issueEn = 1; issueAddr = 5'd0; wrEn = 1; wrAddr = 5'd0; wrData = 32'hFF;
        rd0(5'd0, 1'b1);
        #1 chk("x0_rd", rdData[31:0], 32'h0);
        chk("x0_stall", {31'd0, rdStall[0]}, 32'd0);
        tick(); idle();
        dbgAddr = 5'd0;
        #1 chk("x0_stall_next", {31'd0, rdStall[0]}, 32'd0);
        chk("x0_dbg", dbgData, 32'h0);
        chk("x0_sbErr", {31'd0, sbErr}, 32'd0);

        // ---- kill on x4, then underflow
        wrEn = 1; wrAddr = 5'd4; wrData = 32'h44;
        tick(); idle();
        issueEn = 1; issueAddr = 5'd4; rd0(5'd4, 1'b1);
        tick(); idle();
        #1 chk("kill_pend", {31'd0, rdStall[0]}, 32'd1);
        killEn = 1; killAddr = 5'd4;
        tick(); idle();
        #1 chk("kill_nostall", {31'd0, rdStall[0]}, 32'd0);
        chk("kill_data", rdData[31:0], 32'h44);
        chk("kill_noerr", {31'd0, sbErr}, 32'd0);
        killEn = 1; killAddr = 5'd4;
        tick(); idle();
        #1 chk("kill_underflow", {31'd0, sbErr}, 32'd1);
        tick();
        chk("kill_sticky", {31'd0, sbErr}, 32'd1);

        // ---- overflow after fresh reset
        rst_n = 0; #1 chk("ovf_rst", {31'd0, sbErr}, 32'd0);
        tick(); rst_n = 1;
        issueEn = 1; issueAddr = 5'd10; rd0(5'd10, 1'b1);
        tick(); tick(); tick();
        #1 chk("ovf_at_max", {31'd0, sbErr}, 32'd0);
        tick(); idle();
        #1 chk("ovf_err", {31'd0, sbErr}, 32'd1);
        chk("ovf_stall", {31'd0, rdStall[0]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
